// File: rtl/decimal_decode_pkg.sv
// Shared definitions for the decimal decode arbiter slice.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package decimal_decode_pkg;

  // Width of a requester's binary code.
  localparam int CODE_W     = 4;
  // Width of the one-hot decimal result (digits 0..9).
  localparam int ONEHOT_W   = 10;
  // Largest code that maps to a decimal digit; anything above is an error code.
  localparam int MAX_DIGIT  = 9;
  // Hold counter width, large enough to count the longest 255-cycle window.
  localparam int HOLD_CNT_W = 8;

  // Arbiter FSM: wait for a request, decode the captured code, hold the result.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  // True when the code names a decimal digit (0..9).
  function automatic logic code_is_digit(input logic [CODE_W-1:0] code);
    return (int'(code) <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/Binary_to_Decimal_Convert.sv
// 4-bit binary code to 10-bit one-hot decimal digit decoder; codes 10..15 give all zeros.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows the input code continuously.
module Binary_to_Decimal_Convert
  import decimal_decode_pkg::*;
(
  input  logic [CODE_W-1:0]   i_code,
  output logic [ONEHOT_W-1:0] o_onehot
);

  // Set bit n when the code equals n; out-of-range codes match no bit.
  always_comb begin
    o_onehot = '0;
    for (int n = 0; n < ONEHOT_W; n++) begin
      if (int'(i_code) == n) begin
        o_onehot[n] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decimal_decode_arbiter.sv
// Two-requester round-robin arbiter that captures a 4-bit code and presents its one-hot decimal decode.
// Latency: req sampled at edge N -> gnt in cycle N+1, out_valid from cycle N+2 for HOLD_CYCLES cycles.
// Backpressure: requesters hold req until gnt; requests seen during DECODE/HOLD simply wait for IDLE.
module decimal_decode_arbiter
  import decimal_decode_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [CODE_W-1:0]   code0,
  input  logic                req1,
  input  logic [CODE_W-1:0]   code1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [ONEHOT_W-1:0] decimal,
  output logic                out_valid,
  output logic                out_owner,
  output logic                err
);

  // The counter is loaded with HOLD_CYCLES-1 on entering HOLD and the window
  // ends on the cycle it reads zero, giving exactly HOLD_CYCLES valid cycles.
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

  state_t                r_state;
  logic                  r_ptr;        // round-robin pointer: requester preferred on a tie
  logic [CODE_W-1:0]     r_code;       // code captured at grant, feeds the decoder
  logic                  r_owner;      // requester captured at grant
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic [ONEHOT_W-1:0]   r_decimal;
  logic                  r_valid;
  logic                  r_out_owner;
  logic                  r_err;
  logic [HOLD_CNT_W-1:0] r_cnt;

  logic                  w_any_req;
  logic                  w_sel;
  logic [CODE_W-1:0]     w_sel_code;
  logic [ONEHOT_W-1:0]   w_onehot;
  logic                  w_code_err;

  assign w_any_req  = req0 | req1;
  assign w_sel_code = w_sel ? code1 : code0;
  assign w_code_err = ~code_is_digit(r_code);

  // Pick the requester to serve: the only one asking, or the pointer's choice on a tie.
  always_comb begin
    w_sel = 1'b0;
    if (req0 && req1) begin
      w_sel = r_ptr;
    end else if (req1) begin
      w_sel = 1'b1;
    end
  end

  Binary_to_Decimal_Convert u_b2d (
    .i_code   (r_code),
    .o_onehot (w_onehot)
  );

  // Arbiter FSM with hold counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_code      <= '0;
      r_owner     <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_decimal   <= '0;
      r_valid     <= 1'b0;
      r_out_owner <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // Grants are single-cycle pulses unless re-armed below.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_code  <= w_sel_code;
            r_owner <= w_sel;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
            // The loser of this grant is preferred next time.
            r_ptr   <= ~w_sel;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_decimal   <= w_onehot;
          r_err       <= w_code_err;
          r_out_owner <= r_owner;
          r_valid     <= 1'b1;
          r_cnt       <= HOLD_LOAD;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_valid     <= 1'b0;
            r_decimal   <= '0;
            r_err       <= 1'b0;
            r_out_owner <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign decimal   = r_decimal;
  assign out_valid = r_valid;
  assign out_owner = r_out_owner;
  assign err       = r_err;

  // Only one requester may ever be granted in a cycle.
  a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

  // A valid result is only ever presented from the HOLD state.
  a_valid_in_hold: assert property (@(posedge clk) disable iff (rst) out_valid |-> (r_state == ST_HOLD));

endmodule
